// File: rtl/flying_logo.sv
// Purpose : pixel source drawing a bordered square logo that bounces around the visible area.
// Latency : vga_data is registered, one clk after h_addr/v_addr; motion state moves on the frame_tick edge.
// Backpressure: none, free-running pixel stream that follows the scan addresses every clk.
//
// Ports:
//   clk, clrn        pixel clock, asynchronous active-low reset
//   en, mode         motion enable, speed select (0 paused, 1 /4, 2 /2, 3 every frame)
//   h_addr, v_addr   scan coordinates from the timing generator
//   vga_data         {R,G,B} pixel colour
//   pos_x, pos_y     logo top-left corner
//   bounce_cnt       wall-bounce event counter (wraps)
//   frame_tick       one-cycle pulse per detected frame start
module flying_logo #(
    parameter int          SIZE     = 64,
    parameter int          STEP     = 2,
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [23:0] BG       = 24'h000000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    output logic [23:0] vga_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [7:0]  bounce_cnt,
    output logic        frame_tick
);

    localparam logic [10:0] XMAX = 11'(H_ACTIVE - SIZE);
    localparam logic [10:0] YMAX = 11'(V_ACTIVE - SIZE);
    localparam logic [10:0] STP  = 11'(STEP);
    localparam logic [10:0] SZ   = 11'(SIZE);
    localparam logic [10:0] HA   = 11'(H_ACTIVE);
    localparam logic [10:0] VA   = 11'(V_ACTIVE);
    localparam logic [10:0] BW   = 11'd4;

    logic [9:0]  r_prev_h;
    logic [9:0]  r_prev_v;
    logic [1:0]  r_div;
    logic [9:0]  r_pos_x;
    logic [9:0]  r_pos_y;
    logic        r_dx_neg;
    logic        r_dy_neg;
    logic [2:0]  r_idx;
    logic [7:0]  r_bcnt;
    logic        r_tick;
    logic [23:0] r_vga;

    // One axis step: returns {bounce, next_dir_neg, next_pos}. 11-bit math keeps
    // the wall test free of wrap-around.
    function automatic logic [11:0] f_axis(input logic [9:0] p, input logic neg,
                                           input logic [10:0] pmax);
        logic [10:0] ext;
        logic [10:0] nxt;
        ext = {1'b0, p};
        nxt = ext;
        if (!neg && ((ext + STP) > pmax)) begin
            nxt    = pmax;
            f_axis = {2'b11, nxt[9:0]};
        end else if (neg && (ext < STP)) begin
            f_axis = {2'b10, 10'd0};
        end else if (neg) begin
            nxt    = ext - STP;
            f_axis = {2'b01, nxt[9:0]};
        end else begin
            nxt    = ext + STP;
            f_axis = {2'b00, nxt[9:0]};
        end
    endfunction

    // Frame start: first cycle of (0,0) after any other pair, so a long hold
    // at the origin during blanking yields a single tick.
    logic w_at_org;
    logic w_prev_org;
    logic w_tick;
    assign w_at_org   = (h_addr == 10'd0) && (v_addr == 10'd0);
    assign w_prev_org = (r_prev_h == 10'd0) && (r_prev_v == 10'd0);
    assign w_tick     = w_at_org && !w_prev_org;

    logic w_rate;
    always_comb begin
        w_rate = 1'b0;
        case (mode)
            2'd3:    w_rate = 1'b1;
            2'd2:    w_rate = ~r_div[0];
            2'd1:    w_rate = (r_div == 2'd0);
            default: w_rate = 1'b0;
        endcase
    end

    logic        w_upd;
    logic [11:0] w_ax;
    logic [11:0] w_ay;
    logic        w_bnc;
    assign w_upd = w_tick && en && w_rate;
    assign w_ax  = f_axis(r_pos_x, r_dx_neg, XMAX);
    assign w_ay  = f_axis(r_pos_y, r_dy_neg, YMAX);
    assign w_bnc = w_ax[11] | w_ay[11];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_prev_h <= 10'h3FF;
            r_prev_v <= 10'h3FF;
            r_div    <= 2'd0;
            r_pos_x  <= 10'd0;
            r_pos_y  <= 10'd0;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
            r_idx    <= 3'd0;
            r_bcnt   <= 8'd0;
            r_tick   <= 1'b0;
        end else begin
            r_prev_h <= h_addr;
            r_prev_v <= v_addr;
            r_tick   <= w_tick;
            if (w_tick && en) begin
                r_div <= r_div + 2'd1;
            end
            if (w_upd) begin
                r_pos_x  <= w_ax[9:0];
                r_dx_neg <= w_ax[10];
                r_pos_y  <= w_ay[9:0];
                r_dy_neg <= w_ay[10];
                // A corner hit bounces both axes but counts once.
                if (w_bnc) begin
                    r_idx  <= r_idx + 3'd1;
                    r_bcnt <= r_bcnt + 8'd1;
                end
            end
        end
    end

    // Render with the position that will be live after this edge, so the
    // origin pixel of a new frame already uses that frame's position.
    logic [9:0]  w_rx;
    logic [9:0]  w_ry;
    logic [2:0]  w_ridx;
    assign w_rx   = w_upd ? w_ax[9:0] : r_pos_x;
    assign w_ry   = w_upd ? w_ay[9:0] : r_pos_y;
    assign w_ridx = (w_upd && w_bnc) ? (r_idx + 3'd1) : r_idx;

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_x0;
    logic [10:0] w_x1;
    logic [10:0] w_y0;
    logic [10:0] w_y1;
    assign w_h  = {1'b0, h_addr};
    assign w_v  = {1'b0, v_addr};
    assign w_x0 = {1'b0, w_rx};
    assign w_x1 = w_x0 + SZ;
    assign w_y0 = {1'b0, w_ry};
    assign w_y1 = w_y0 + SZ;

    logic w_vis;
    logic w_in;
    logic w_brd;
    assign w_vis = (w_h < HA) && (w_v < VA);
    assign w_in  = (w_h >= w_x0) && (w_h < w_x1) && (w_v >= w_y0) && (w_v < w_y1);
    assign w_brd = (w_h < (w_x0 + BW)) || (w_h >= (w_x1 - BW)) ||
                   (w_v < (w_y0 + BW)) || (w_v >= (w_y1 - BW));

    logic [23:0] w_pal;
    always_comb begin
        w_pal = 24'hFF0000;
        case (w_ridx)
            3'd0:    w_pal = 24'hFF0000;
            3'd1:    w_pal = 24'h00FF00;
            3'd2:    w_pal = 24'h0000FF;
            3'd3:    w_pal = 24'hFFFF00;
            3'd4:    w_pal = 24'h00FFFF;
            3'd5:    w_pal = 24'hFF00FF;
            3'd6:    w_pal = 24'hFF8000;
            default: w_pal = 24'h8000FF;
        endcase
    end

    logic [23:0] w_pix;
    always_comb begin
        w_pix = BG;
        if (w_vis && w_in) begin
            w_pix = w_brd ? 24'hFFFFFF : w_pal;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_vga <= 24'h000000;
        end else begin
            r_vga <= w_pix;
        end
    end

    assign vga_data   = r_vga;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign bounce_cnt = r_bcnt;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_flying_logo.sv
module tb_flying_logo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic        en;
    logic [1:0]  mode;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;

    logic [23:0] vga_data;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [7:0]  bounce_cnt;
    logic        frame_tick;

    logic [23:0] sq_vga_data;
    logic [9:0]  sq_pos_x;
    logic [9:0]  sq_pos_y;
    logic [7:0]  sq_bounce_cnt;
    logic        sq_frame_tick;

    flying_logo dut (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode),
        .h_addr(h_addr), .v_addr(v_addr),
        .vga_data(vga_data), .pos_x(pos_x), .pos_y(pos_y),
        .bounce_cnt(bounce_cnt), .frame_tick(frame_tick)
    );

    // Square field so both axes reach their far walls on the same update.
    flying_logo #(.V_ACTIVE(640)) dut_sq (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode),
        .h_addr(h_addr), .v_addr(v_addr),
        .vga_data(sq_vga_data), .pos_x(sq_pos_x), .pos_y(sq_pos_y),
        .bounce_cnt(sq_bounce_cnt), .frame_tick(sq_frame_tick)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    always @(negedge clk) if (frame_tick) n_ticks <= n_ticks + 1;

    typedef struct {
        int x; int y; bit dxn; bit dyn; int idx; int bc;
    } mdl_t;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t  sbq[$];
    mdl_t m1;
    mdl_t m2;
    int   mdiv;

    logic [23:0] pal [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                             24'h00FFFF, 24'hFF00FF, 24'hFF8000, 24'h8000FF};

    function automatic mdl_t upd(mdl_t m, int xmax, int ymax);
        bit b = 0;
        if (!m.dxn && m.x + 2 > xmax) begin m.x = xmax; m.dxn = 1; b = 1; end
        else if (m.dxn && m.x < 2)    begin m.x = 0;    m.dxn = 0; b = 1; end
        else                           m.x = m.dxn ? m.x - 2 : m.x + 2;
        if (!m.dyn && m.y + 2 > ymax) begin m.y = ymax; m.dyn = 1; b = 1; end
        else if (m.dyn && m.y < 2)    begin m.y = 0;    m.dyn = 0; b = 1; end
        else                           m.y = m.dyn ? m.y - 2 : m.y + 2;
        if (b) begin m.idx = (m.idx + 1) % 8; m.bc = (m.bc + 1) % 256; end
        return m;
    endfunction

    task automatic model_reset();
        m1 = '{0, 0, 0, 0, 0, 0};
        m2 = '{0, 0, 0, 0, 0, 0};
        mdiv = 0;
    endtask

    task automatic model_tick();
        bit u;
        if (en) begin
            u = (mode == 2'd3) || (mode == 2'd2 && mdiv % 2 == 0) ||
                (mode == 2'd1 && mdiv == 0);
            mdiv = (mdiv + 1) % 4;
            if (u) begin
                m1 = upd(m1, 576, 416);
                m2 = upd(m2, 576, 576);
            end
        end
    endtask

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0:       return {8'd0, vga_data};
            1:       return {22'd0, pos_x};
            2:       return {22'd0, pos_y};
            3:       return {24'd0, bounce_cnt};
            4:       return {31'd0, frame_tick};
            5:       return {22'd0, sq_pos_x};
            6:       return {22'd0, sq_pos_y};
            7:       return {24'd0, sq_bounce_cnt};
            8:       return {8'd0, sq_vga_data};
            default: return {31'd0, sq_frame_tick};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(string tag, int sel, logic [31:0] e);
        sb_t s;
        s.tag = tag; s.sel = sel; s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic drain();
        sb_t s;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk(s.tag, obs(s.sel), s.exp);
        end
    endtask

    task automatic apply(int h, int v);
        @(negedge clk);
        h_addr = 10'(h);
        v_addr = 10'(v);
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic push_state();
        push("pos_x", 1, m1.x);
        push("pos_y", 2, m1.y);
        push("bounce_cnt", 3, m1.bc);
        push("sq_pos_x", 5, m2.x);
        push("sq_pos_y", 6, m2.y);
        push("sq_bounce_cnt", 7, m2.bc);
    endtask

    // One frame start at the origin, then move off it so the next call ticks again.
    task automatic tick();
        model_tick();
        push("tick_hi", 4, 1);
        push("sq_tick_hi", 9, 1);
        push_state();
        apply(0, 0);
        push("tick_lo", 4, 0);
        apply(1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int xs;
        int bc0;
        int sbc0;
        int g;

        clrn = 1'b0; en = 1'b1; mode = 2'd3; h_addr = 10'd0; v_addr = 10'd0;
        model_reset();
        #12;
        push("rst_vga", 0, 0);
        push("rst_tick", 4, 0);
        push_state();
        push("rst_sq_vga", 8, 0);
        drain();

        // First cycle after release at (0,0) ticks thanks to the (1023,1023) reset history.
        @(negedge clk);
        clrn = 1'b1;
        model_tick();
        push("first_tick", 4, 1);
        push("first_x", 1, 2);
        push("first_y", 2, 2);
        push_state();
        @(posedge clk);
        #1;
        drain();
        push("first_tick_lo", 4, 0);
        apply(1, 0);

        // Partial scan of rows: no tick except at the origin.
        t0 = n_ticks;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 800; c++)
                if (!(r == 0 && c == 0)) apply(c, r);
        chk("scan_no_tick", 32'(n_ticks - t0), 0);
        tick();
        chk("scan_one_tick", 32'(n_ticks - t0), 1);
        chk("second_x", {22'd0, pos_x}, 4);

        // Move to (100,100), palette index 0.
        g = 0;
        while (m1.x != 100 && g < 200) begin tick(); g++; end
        chk("reach_100", 32'(m1.x), 100);
        push("px_corner",   0, 24'hFFFFFF); apply(100, 100);
        push("px_fill",     0, 24'hFF0000); apply(120, 120);
        push("px_left_out", 0, 24'h000000); apply(99, 120);
        push("px_far_brd",  0, 24'hFFFFFF); apply(163, 163);
        push("px_right_out",0, 24'h000000); apply(164, 120);
        push("px_offscreen",0, 24'h000000); apply(700, 120);
        push("px_brd_in",   0, 24'hFFFFFF); apply(103, 120);
        push("px_fill_edge",0, 24'hFF0000); apply(104, 120);
        push("px_below_out",0, 24'h000000); apply(120, 164);
        push("px_above_out",0, 24'h000000); apply(120, 99);

        // Origin held for 100 cycles: one tick, mode 0 keeps position.
        mode = 2'd0;
        apply(1, 0);
        t0 = n_ticks;
        model_tick();
        push("held_tick", 4, 1);
        push_state();
        apply(0, 0);
        for (int i = 0; i < 99; i++) begin
            push("held_no_tick", 4, 0);
            apply(0, 0);
        end
        apply(1, 0);
        chk("held_ticks", 32'(n_ticks - t0), 1);

        // Update rates.
        mode = 2'd1; xs = m1.x;
        for (int i = 0; i < 8; i++) tick();
        chk("mode1_delta", 32'(int'(pos_x) - xs), 4);
        mode = 2'd2; xs = m1.x;
        for (int i = 0; i < 8; i++) tick();
        chk("mode2_delta", 32'(int'(pos_x) - xs), 8);
        mode = 2'd0; xs = m1.x;
        for (int i = 0; i < 8; i++) tick();
        chk("mode0_delta", 32'(int'(pos_x) - xs), 0);
        en = 1'b0; mode = 2'd3; xs = m1.x; t0 = n_ticks;
        for (int i = 0; i < 4; i++) tick();
        chk("freeze_delta", 32'(int'(pos_x) - xs), 0);
        chk("freeze_ticks", 32'(n_ticks - t0), 4);
        en = 1'b1; mode = 2'd1; xs = m1.x;
        for (int i = 0; i < 4; i++) tick();
        chk("resume_delta", 32'(int'(pos_x) - xs), 2);

        // Right wall on the main field, corner on the square field.
        mode = 2'd3;
        g = 0;
        while (m1.x != 574 && g < 400) begin tick(); g++; end
        chk("reach_574", {22'd0, pos_x}, 574);
        bc0 = m1.bc; sbc0 = m2.bc;
        tick();
        chk("rw_arrive_x", {22'd0, pos_x}, 576);
        chk("rw_arrive_bc", {24'd0, bounce_cnt}, 32'(bc0));
        chk("cn_arrive_x", {22'd0, sq_pos_x}, 576);
        chk("cn_arrive_y", {22'd0, sq_pos_y}, 576);
        tick();
        chk("rw_bounce_x", {22'd0, pos_x}, 576);
        chk("rw_bounce_bc", {24'd0, bounce_cnt}, 32'((bc0 + 1) % 256));
        chk("cn_bounce_bc", {24'd0, sq_bounce_cnt}, 32'((sbc0 + 1) % 256));
        tick();
        chk("rw_return_x", {22'd0, pos_x}, 574);
        chk("cn_return_x", {22'd0, sq_pos_x}, 574);
        chk("cn_return_y", {22'd0, sq_pos_y}, 574);
        chk("cn_return_bc", {24'd0, sq_bounce_cnt}, 32'((sbc0 + 1) % 256));

        // Paint a fill pixel, then reset asynchronously between clock edges.
        push("pre_rst_fill", 0, {8'd0, pal[m1.idx]});
        apply(m1.x + 20, m1.y + 20);
        @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_vga", {8'd0, vga_data}, 0);
        chk("arst_pos_x", {22'd0, pos_x}, 0);
        chk("arst_pos_y", {22'd0, pos_y}, 0);
        chk("arst_bc", {24'd0, bounce_cnt}, 0);
        chk("arst_tick", {31'd0, frame_tick}, 0);
        chk("arst_sq_pos_x", {22'd0, sq_pos_x}, 0);
        chk("arst_sq_bc", {24'd0, sq_bounce_cnt}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
